fft_frame_loader: RTL and testbench

- Sequencer between the UART byte receiver and the FFT core.
- Hunts for a sync byte, then assembles little-endian 16-bit samples from the received bytes and writes them into the FFT sample buffer.
- After a full frame it pulses the FFT start, holds off new data until the FFT reports done, and aborts partial frames on inter-byte timeout.

---
 rtl/fft_frame_loader.sv | 131 +++++++++++++
 tb/tb_fft_frame_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// UART-to-FFT frame sequencer: sync hunt, LE sample assembly, buffer writes,
// FFT start/hold-off, inter-byte timeout abort and busy-drop counting.
module fft_frame_loader #(
  parameter int N_SAMPLES   = 64,
  parameter int ADDR_W      = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYC = 4340,
  parameter int TMR_W       = 16
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, LO, HI, START, WAIT_FFT
  } state_t;

  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_SAMPLES - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   idx, idx_nx;
  logic [7:0]          lo, lo_nx;
  logic [TMR_W-1:0]    tmr, tmr_nx;
  logic                wr_en_nx, start_nx, busy_nx, err_nx;
  logic [ADDR_W-1:0]   wr_addr_nx;
  logic [15:0]         wr_data_nx;
  logic [7:0]          drop_nx;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      idx       <= '0;
      lo        <= '0;
      tmr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      fft_start <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      lo        <= lo_nx;
      tmr       <= tmr_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      fft_start <= start_nx;
      busy      <= busy_nx;
      frame_err <= err_nx;
      drop_cnt  <= drop_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    lo_nx      = lo;
    tmr_nx     = '0;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    start_nx   = 1'b0;
    busy_nx    = busy;
    err_nx     = 1'b0;
    drop_nx    = drop_cnt;
    unique case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_nx = LO;
          busy_nx  = 1'b1;
          idx_nx   = '0;
        end
      end
      LO, HI: begin
        if (rx_valid) begin
          if (state == LO) begin
            lo_nx    = rx_data;
            state_nx = HI;
          end else begin
            wr_en_nx   = 1'b1;
            wr_addr_nx = idx;
            wr_data_nx = {rx_data, lo};
            if (idx == IDX_LAST) begin
              state_nx = START;
            end else begin
              idx_nx   = idx + 1'b1;
              state_nx = LO;
            end
          end
        end else if (tmr == TMR_LAST) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          idx_nx   = '0;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      START: begin
        start_nx = 1'b1;
        state_nx = WAIT_FFT;
      end
      WAIT_FFT: begin
        if (fft_done) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // bytes arriving while the FFT owns the buffer are lost
    if ((state == START || state == WAIT_FFT) && rx_valid
        && drop_cnt != 8'hFF)
      drop_nx = drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: sample table, write scoreboard,
// timeout/drop/reset sequences on a 4-sample frame.
module tb_fft_frame_loader;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          clr_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          fft_done = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          fft_start;
  logic          busy;
  logic          frame_err;
  logic [7:0]    drop_cnt;

  fft_frame_loader #(
    .N_SAMPLES(4), .ADDR_W(AW), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(100), .TMR_W(16)
  ) dut (
    .clock(clock), .clr_n(clr_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fft_start(fft_start), .fft_done(fft_done),
    .busy(busy), .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  vec_t tv [8];
  wr_t  exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_err = 0;
  int   err_cyc = 0;
  int   t0 = 0;
  logic prev_wr = 1'b0;
  logic busy_low = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    wr_t e;
    cyc++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
    if (fft_start) begin
      n_start++;
      check("start_after_last_wr", 32'(prev_wr), 32'd1);
    end
    if (frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (!busy) busy_low = 1'b1;
    prev_wr = wr_en;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clock);
    sample();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic send_sample(input int j, input int i, input int gap);
    send(tv[j].lo, gap);
    exp_q.push_back(wr_t'{AW'(i), tv[j].exp});
    send(tv[j].hi, gap);
  endtask

  task automatic send_frame(input int base, input int gap);
    send(8'hA5, gap);
    for (int i = 0; i < 4; i++) send_sample(base + i, i, gap);
    repeat (2) step(1'b0, 8'h00);
  endtask

  task automatic finish_fft();
    fft_done = 1'b1;
    step(1'b0, 8'h00);
    fft_done = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    tv[0] = '{8'h34, 8'h12, 16'h1234};
    tv[1] = '{8'h78, 8'h56, 16'h5678};
    tv[2] = '{8'hBC, 8'h9A, 16'h9ABC};
    tv[3] = '{8'hF0, 8'hDE, 16'hDEF0};
    tv[4] = '{8'hA5, 8'h01, 16'h01A5};
    tv[5] = '{8'h00, 8'hA5, 16'hA500};
    tv[6] = '{8'hFF, 8'hFF, 16'hFFFF};
    tv[7] = '{8'h5A, 8'hC3, 16'hC35A};

    repeat (2) @(negedge clock);
    check("rst_outs", 32'({wr_en, fft_start, busy, frame_err,
                           wr_addr, wr_data}), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    clr_n = 1'b1;
    @(negedge clock);

    // nominal frame, 20 clocks between bytes
    n_start = 0;
    busy_low = 1'b0;
    send_frame(0, 19);
    check("t1_busy_held", 32'(busy_low), 32'd0);
    check("t1_starts", 32'(n_start), 32'd1);
    check("t1_writes_done", 32'(exp_q.size()), 32'd0);
    check("t1_busy_wait", 32'(busy), 32'd1);
    finish_fft();

    // pre-sync garbage is ignored, not counted
    send(8'h00, 2);
    send(8'hFF, 2);
    check("t2_busy_idle", 32'(busy), 32'd0);
    check("t2_drop", 32'(drop_cnt), 32'd0);
    send_frame(4, 0);
    check("t2_starts", 32'(n_start), 32'd2);
    finish_fft();

    // timeout abort
    n_err = 0;
    send(8'hA5, 0);
    send(8'h11, 0);
    exp_q.push_back(wr_t'{AW'(0), 16'h2211});
    send(8'h22, 0);
    t0 = cyc;
    repeat (150) step(1'b0, 8'h00);
    check("t3_err_count", 32'(n_err), 32'd1);
    check("t3_err_latency", 32'(err_cyc - t0), 32'd100);
    check("t3_busy", 32'(busy), 32'd0);
    send_frame(0, 0);
    check("t3_restart_done", 32'(exp_q.size()), 32'd0);
    finish_fft();

    // drops while FFT busy saturate
    send_frame(4, 0);
    repeat (300) step(1'b1, 8'h3C);
    check("t4_drop_sat", 32'(drop_cnt), 32'd255);
    finish_fft();
    send(8'hA5, 0);
    check("t4_sync_accept", 32'(busy), 32'd1);

    // byte landing exactly on the expiry cycle wins
    n_err = 0;
    repeat (99) step(1'b0, 8'h00);
    send(8'h12, 0);
    repeat (99) step(1'b0, 8'h00);
    exp_q.push_back(wr_t'{AW'(0), 16'hA512});
    send(8'hA5, 0);
    for (int i = 1; i < 4; i++) send_sample(i, i, 0);
    repeat (2) step(1'b0, 8'h00);
    check("t5_no_err", 32'(n_err), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    finish_fft();

    // async reset mid-frame
    send(8'hA5, 0);
    send_sample(0, 0, 0);
    send_sample(1, 1, 0);
    rx_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'({wr_en, fft_start, busy, frame_err,
                              wr_addr, wr_data}), 32'd0);
    check("t6_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clock);
    clr_n = 1'b1;
    send_frame(4, 0);
    check("t6_frame_done", 32'(exp_q.size()), 32'd0);
    finish_fft();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
